// File: rtl/snake_game_fsm.sv
// rtl/snake_game_fsm.sv - snake game sequencer: body, direction latch, food placement, win/lose
module snake_game_fsm #(
  parameter logic [7:0] START_POS = 8'h88,
  parameter int         START_LEN = 3,
  parameter int         WIN_LEN   = 15,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         BtnU,
  input  logic         BtnD,
  input  logic         BtnL,
  input  logic         BtnR,
  input  logic         Tick,
  output logic         Qi,
  output logic         Qc,
  output logic         Qw,
  output logic         Ql,
  output logic [7:0]   Food,
  output logic [3:0]   Length,
  output logic [127:0] Locations_Flat
);

  typedef enum logic [2:0] {INIT, PLACE, PLAY, WIN, LOSE} state_t;

  // Directions are encoded so that the opposite of d is d ^ 1.
  localparam logic [1:0] DIR_U = 2'd0;
  localparam logic [1:0] DIR_D = 2'd1;
  localparam logic [1:0] DIR_L = 2'd2;
  localparam logic [1:0] DIR_R = 2'd3;

  localparam logic [3:0] START_LEN_L = 4'(START_LEN);
  localparam logic [3:0] WIN_LEN_L   = 4'(WIN_LEN);

  state_t     state_q, state_nxt;
  logic [1:0] dir_q, dir_nxt, pend_q, pend_nxt;
  logic [7:0] lfsr_q, lfsr_nxt;
  logic [7:0] seg_q   [16];
  logic [7:0] seg_nxt [16];
  logic [7:0] food_nxt;
  logic [3:0] len_nxt, len_inc;
  logic [7:0] head, nh;
  logic       wall_hit, body_hit, place_hit;
  logic       btn_any, do_shift;
  logic [1:0] btn_dir;

  // Priority-encode the direction buttons (U > D > L > R)
  always_comb begin
    btn_any = BtnU | BtnD | BtnL | BtnR;
    btn_dir = DIR_R;
    if (BtnU)      btn_dir = DIR_U;
    else if (BtnD) btn_dir = DIR_D;
    else if (BtnL) btn_dir = DIR_L;
  end

  // Next head cell, wall test, self-collision test and food-candidate test
  always_comb begin
    head     = seg_q[0];
    nh       = head;
    wall_hit = 1'b0;
    case (pend_q)
      DIR_U: begin nh = head - 8'd16; wall_hit = (head[7:4] == 4'd0);  end
      DIR_D: begin nh = head + 8'd16; wall_hit = (head[7:4] == 4'd15); end
      DIR_L: begin nh = head - 8'd1;  wall_hit = (head[3:0] == 4'd0);  end
      default: begin nh = head + 8'd1; wall_hit = (head[3:0] == 4'd15); end
    endcase
    body_hit  = 1'b0;
    place_hit = 1'b0;
    for (int i = 0; i < 16; i++) begin
      // the tail slot is about to vacate, so it cannot be hit
      if ((i < int'(Length) - 1) && (seg_q[i] == nh))     body_hit  = 1'b1;
      if ((i < int'(Length))     && (seg_q[i] == lfsr_q)) place_hit = 1'b1;
    end
  end

  // Next-state, body, length, food and direction-latch logic
  always_comb begin
    state_nxt = state_q;
    dir_nxt   = dir_q;
    pend_nxt  = pend_q;
    lfsr_nxt  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    food_nxt  = Food;
    len_nxt   = Length;
    len_inc   = Length + 4'd1;
    do_shift  = 1'b0;
    for (int i = 0; i < 16; i++) seg_nxt[i] = seg_q[i];

    case (state_q)
      INIT: begin
        if (Start) begin
          for (int i = 0; i < 16; i++)
            seg_nxt[i] = (i < START_LEN) ? (START_POS - 8'(i)) : 8'h00;
          len_nxt   = START_LEN_L;
          state_nxt = PLACE;
        end
      end
      PLACE: begin
        if (!place_hit) begin
          food_nxt  = lfsr_q;
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (Tick) begin
          dir_nxt = pend_q;
          if (wall_hit) begin
            state_nxt = LOSE;
          end else if (nh == Food) begin
            do_shift  = 1'b1;
            len_nxt   = len_inc;
            state_nxt = (len_inc == WIN_LEN_L) ? WIN : PLACE;
          end else if (body_hit) begin
            state_nxt = LOSE;
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      default: begin
        if (Start) begin
          for (int i = 0; i < 16; i++) seg_nxt[i] = 8'h00;
          len_nxt   = 4'd0;
          state_nxt = INIT;
        end
      end
    endcase

    if (do_shift) begin
      for (int i = 15; i > 0; i--) seg_nxt[i] = seg_q[i-1];
      seg_nxt[0] = nh;
    end

    // A press opposite to the direction in force after this cycle is dropped
    if (btn_any && (btn_dir != (dir_nxt ^ 2'b01)))
      pend_nxt = btn_dir;

    // A new game always starts heading right
    if ((state_q == INIT) && Start) begin
      dir_nxt  = DIR_R;
      pend_nxt = DIR_R;
    end
  end

  // State, datapath and registered flag outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= INIT;
      dir_q   <= DIR_R;
      pend_q  <= DIR_R;
      lfsr_q  <= LFSR_SEED;
      Food    <= 8'h00;
      Length  <= 4'd0;
      Qi      <= 1'b1;
      Qc      <= 1'b0;
      Qw      <= 1'b0;
      Ql      <= 1'b0;
      for (int i = 0; i < 16; i++) seg_q[i] <= 8'h00;
    end else begin
      state_q <= state_nxt;
      dir_q   <= dir_nxt;
      pend_q  <= pend_nxt;
      lfsr_q  <= lfsr_nxt;
      Food    <= food_nxt;
      Length  <= len_nxt;
      Qi      <= (state_nxt == INIT);
      Qc      <= (state_nxt == PLAY);
      Qw      <= (state_nxt == WIN);
      Ql      <= (state_nxt == LOSE);
      for (int i = 0; i < 16; i++) seg_q[i] <= seg_nxt[i];
    end
  end

  // Flatten the body, head in the top byte
  always_comb begin
    Locations_Flat = '0;
    for (int i = 0; i < 16; i++) Locations_Flat[127 - 8*i -: 8] = seg_q[i];
  end

endmodule

// File: tb/tb_snake_game_fsm.sv
// tb/tb_snake_game_fsm.sv - self-checking bench for snake_game_fsm
module tb_snake_game_fsm;

  logic Clk = 1'b0, Reset = 1'b1, Start = 1'b0, Tick = 1'b0;
  logic BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;
  logic Qi, Qc, Qw, Ql, Qi2, Qc2, Qw2, Ql2;
  logic [7:0]   Food, Food2;
  logic [3:0]   Length, Length2;
  logic [127:0] Locs, Locs2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [143:0] exp_q[$];
  logic [143:0] e;
  logic [7:0]   m_lfsr;

  localparam logic [143:0] RST_VAL = {4'b1000, 8'h00, 4'h0, 128'h0};

  snake_game_fsm u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .Tick(Tick), .Qi(Qi), .Qc(Qc), .Qw(Qw), .Ql(Ql), .Food(Food), .Length(Length), .Locations_Flat(Locs)
  );

  snake_game_fsm #(.WIN_LEN(5)) u_win (
    .Clk(Clk), .Reset(Reset), .Start(Start), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .Tick(Tick), .Qi(Qi2), .Qc(Qc2), .Qw(Qw2), .Ql(Ql2), .Food(Food2), .Length(Length2), .Locations_Flat(Locs2)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  // Reference food LFSR, free-running like the game's
  always @(posedge Clk or posedge Reset) begin
    if (Reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic logic [7:0] predict_food(input logic [7:0] start, input logic [127:0] body, input int len);
    logic [7:0] l;
    bit hit;
    l = start;
    for (int n = 0; n < 256; n++) begin
      hit = 1'b0;
      for (int i = 0; i < len; i++) if (body[127 - 8*i -: 8] == l) hit = 1'b1;
      if (!hit) return l;
      l = lfsr_next(l);
    end
    return 8'h00;
  endfunction

  task automatic step(input logic s, input logic u, input logic d, input logic l, input logic r, input logic t);
    Start = s; BtnU = u; BtnD = d; BtnL = l; BtnR = r; Tick = t;
    @(posedge Clk); #1;
    Start = 0; BtnU = 0; BtnD = 0; BtnL = 0; BtnR = 0; Tick = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  task automatic wait_qc(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int k = 0; k <= max_cycles; k++) begin
      if (Qc === 1'b1) begin ok = 1'b1; break; end
      step(0, 0, 0, 0, 0, 0);
    end
  endtask

  // Idle until the next clock edge will leave target in the LFSR
  task automatic idle_until(input logic [7:0] target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (lfsr_next(m_lfsr) === target) begin ok = 1'b1; break; end
      step(0, 0, 0, 0, 0, 0);
    end
  endtask

  // Reset, time Start so the first food candidate is target, wait for play
  task automatic start_game(input logic [7:0] target, output bit ok);
    bit synced;
    do_reset();
    idle_until(target, synced);
    exp_q.push_back({136'h0, target});
    step(1, 0, 0, 0, 0, 0);
    wait_qc(16, ok);
    ok = ok && synced;
  endtask

  task automatic test_reset();
    bit ok;
    logic [7:0] f;
    do_reset();
    exp_q.push_back(RST_VAL);
    e = exp_q.pop_front();
    n_checks++; if ({Qi, Qc, Qw, Ql, Food, Length, Locs} !== e) begin n_fail++; $display("FAIL reset_state: got %h want %h", {Qi, Qc, Qw, Ql, Food, Length, Locs}, e); end
    exp_q.push_back({4'b0000, 8'h00, 4'd3, 24'h888786, 104'h0});
    step(1, 0, 0, 0, 0, 0);
    e = exp_q.pop_front();
    n_checks++; if ({Qi, Qc, Qw, Ql, Length, Locs} !== {e[143:140], e[131:0]}) begin n_fail++; $display("FAIL start_load: got %h want %h", {Qi, Qc, Qw, Ql, Length, Locs}, {e[143:140], e[131:0]}); end
    exp_q.push_back({136'h0, predict_food(m_lfsr, {24'h888786, 104'h0}, 3)});
    wait_qc(256, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || Food !== e[7:0]) begin n_fail++; $display("FAIL first_food: qc=%b got %h want %h", ok, Food, e[7:0]); end
    f = Food;
    n_checks++; if (f == 8'h00 || f == 8'h88 || f == 8'h87 || f == 8'h86) begin n_fail++; $display("FAIL food_off_body: got %h want not 00/88/87/86", f); end
  endtask

  task automatic test_move();
    bit ok;
    start_game(8'h35, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || Food !== e[7:0]) begin n_fail++; $display("FAIL move_food: ok=%b got %h want %h", ok, Food, e[7:0]); end
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back({136'h0, 8'h88 + 8'(k)});
      step(0, 0, 0, 0, 0, 1);
      e = exp_q.pop_front();
      n_checks++; if (Locs[127:120] !== e[7:0]) begin n_fail++; $display("FAIL move_head%0d: got %h want %h", k, Locs[127:120], e[7:0]); end
    end
    n_checks++; if ({Length, Locs[127:104]} !== {4'd3, 24'h8B8A89}) begin n_fail++; $display("FAIL move_body: got %h want 38b8a89", {Length, Locs[127:104]}); end
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    n_checks++; if (Locs[127:120] !== 8'h8C) begin n_fail++; $display("FAIL reverse_discard: got %h want 8c", Locs[127:120]); end
    step(0, 1, 0, 0, 0, 1);
    n_checks++; if (Locs[127:120] !== 8'h8D) begin n_fail++; $display("FAIL tick_with_btn: got %h want 8d", Locs[127:120]); end
    step(0, 0, 0, 0, 0, 1);
    n_checks++; if (Locs[127:120] !== 8'h7D) begin n_fail++; $display("FAIL btn_next_tick: got %h want 7d", Locs[127:120]); end
  endtask

  task automatic test_wall();
    bit ok;
    start_game(8'h35, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || Food !== e[7:0]) begin n_fail++; $display("FAIL wall_food: ok=%b got %h want %h", ok, Food, e[7:0]); end
    step(0, 1, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) step(0, 0, 0, 0, 0, 1);
    n_checks++; if ({Qc, Ql, Locs[127:104]} !== {2'b10, 24'h081828}) begin n_fail++; $display("FAIL wall_row0: got %h want 2081828", {Qc, Ql, Locs[127:104]}); end
    step(0, 0, 0, 0, 0, 1);
    n_checks++; if ({Qc, Ql, Length, Locs[127:104]} !== {2'b01, 4'd3, 24'h081828}) begin n_fail++; $display("FAIL wall_lose: got %h want 13081828", {Qc, Ql, Length, Locs[127:104]}); end
    step(1, 0, 0, 0, 0, 0);
    n_checks++; if ({Qi, Length, Locs} !== {1'b1, 4'd0, 128'h0}) begin n_fail++; $display("FAIL lose_to_init: got %h want 1 0 0", {Qi, Length, Locs}); end
  endtask

  task automatic test_eat();
    bit ok;
    start_game(8'h89, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || Food !== e[7:0]) begin n_fail++; $display("FAIL eat_food: ok=%b got %h want %h", ok, Food, e[7:0]); end
    step(0, 0, 0, 0, 0, 1);
    n_checks++; if ({Qi, Qc, Qw, Ql, Length, Locs[127:96]} !== {4'b0000, 4'd4, 32'h89888786}) begin n_fail++; $display("FAIL eat_grow: got %h want 0489888786", {Qi, Qc, Qw, Ql, Length, Locs[127:96]}); end
    exp_q.push_back({136'h0, predict_food(m_lfsr, {32'h89888786, 96'h0}, 4)});
    wait_qc(256, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || Food !== e[7:0]) begin n_fail++; $display("FAIL eat_new_food: ok=%b got %h want %h", ok, Food, e[7:0]); end
  endtask

  task automatic test_tail_no_loss();
    bit ok, synced;
    start_game(8'h89, ok);
    e = exp_q.pop_front();
    idle_until(8'h35, synced);
    exp_q.push_back({136'h0, 8'h35});
    step(0, 0, 0, 0, 0, 1);
    wait_qc(16, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || !synced || Food !== e[7:0]) begin n_fail++; $display("FAIL tail_setup: ok=%b got %h want %h", ok, Food, e[7:0]); end
    step(0, 1, 0, 0, 0, 0); step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 1, 0, 0); step(0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0); step(0, 0, 0, 0, 0, 1);
    n_checks++; if ({Qc, Ql, Length, Locs[127:96]} !== {2'b10, 4'd4, 32'h88787989}) begin n_fail++; $display("FAIL tail_no_loss: got %h want 2488787989", {Qc, Ql, Length, Locs[127:96]}); end
  endtask

  task automatic test_collision_win();
    bit ok, s1, s2;
    logic [3:0] dirs [3];
    dirs[0] = 4'b1000; dirs[1] = 4'b0010; dirs[2] = 4'b0100;
    start_game(8'h89, ok);
    e = exp_q.pop_front();
    idle_until(8'h8A, s1);
    exp_q.push_back({136'h0, 8'h8A});
    step(0, 0, 0, 0, 0, 1);
    wait_qc(16, ok);
    e = exp_q.pop_front();
    n_checks++; if (!ok || !s1 || Food !== e[7:0]) begin n_fail++; $display("FAIL grow_food2: ok=%b got %h want %h", ok, Food, e[7:0]); end
    idle_until(8'h35, s2);
    step(0, 0, 0, 0, 0, 1);
    n_checks++; if ({Qi2, Qc2, Qw2, Ql2, Length2, Locs2[127:88]} !== {4'b0010, 4'd5, 40'h8A89888786}) begin n_fail++; $display("FAIL win_flag: got %h want 258a89888786", {Qi2, Qc2, Qw2, Ql2, Length2, Locs2[127:88]}); end
    wait_qc(16, ok);
    n_checks++; if (!ok || !s2 || Length !== 4'd5 || Food !== 8'h35) begin n_fail++; $display("FAIL grow_len5: ok=%b got %h %h want 5 35", ok, Length, Food); end
    for (int k = 0; k < 3; k++) begin
      step(0, dirs[k][3], dirs[k][2], dirs[k][1], dirs[k][0], 0);
      step(0, 0, 0, 0, 0, 1);
      n_checks++; if ({Qw2, Food2, Length2, Locs2[127:88]} !== {1'b1, 8'h8A, 4'd5, 40'h8A89888786}) begin n_fail++; $display("FAIL win_frozen%0d: got %h", k, {Qw2, Food2, Length2, Locs2[127:88]}); end
    end
    n_checks++; if ({Qc, Ql, Length, Locs[127:88]} !== {2'b01, 4'd5, 40'h797A8A8988}) begin n_fail++; $display("FAIL self_hit: got %h want 15797a8a8988", {Qc, Ql, Length, Locs[127:88]}); end
    step(1, 0, 0, 0, 0, 0);
    n_checks++; if ({Qi, Qi2, Length2} !== {2'b11, 4'd0}) begin n_fail++; $display("FAIL end_to_init: got %h want 30", {Qi, Qi2, Length2}); end
  endtask

  task automatic test_reset_mid_place();
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    n_checks++; if ({Qi, Qc, Qw, Ql, Length} !== {4'b0000, 4'd3}) begin n_fail++; $display("FAIL in_place: got %h want 03", {Qi, Qc, Qw, Ql, Length}); end
    exp_q.push_back(RST_VAL);
    Reset = 1'b1;
    #2;
    e = exp_q.pop_front();
    n_checks++; if ({Qi, Qc, Qw, Ql, Food, Length, Locs} !== e) begin n_fail++; $display("FAIL async_reset: got %h want %h", {Qi, Qc, Qw, Ql, Food, Length, Locs}, e); end
    n_checks++; if ({Qi2, Qc2, Qw2, Ql2, Food2, Length2, Locs2} !== e) begin n_fail++; $display("FAIL async_reset2: got %h want %h", {Qi2, Qc2, Qw2, Ql2, Food2, Length2, Locs2}, e); end
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", n_checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_move();
    test_wall();
    test_eat();
    test_tail_no_loss();
    test_collision_win();
    test_reset_mid_place();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_game_fsm.md
# snake_game_fsm

Game sequencer for the snake datapath. It owns the snake body register file, direction latch, food placement and win/lose decision, and it drives the state flags, food cell, length and flattened location bus that the renderer draws. It sits between the debounced button and step-tick sources and the VGA drawing block.

## Interface
Parameters:
- START_POS, 8'h88, initial head cell (row = bits[7:4], col = bits[3:0]); body extends to its left.
- START_LEN, 3, initial length (2..WIN_LEN-1; START_POS col ≥ START_LEN-1).
- WIN_LEN, 15, length that ends the game as a win (≤15).
- LFSR_SEED, 8'hA5, non-zero food LFSR reset value.

Ports:
- Clk, in, 1, system clock.
- Reset, in, 1, asynchronous, active-high.
- Start, in, 1, single-cycle pulse: begin game / return to idle.
- BtnU, BtnD, BtnL, BtnR, in, 1 each, single-cycle debounced direction pulses.
- Tick, in, 1, single-cycle movement-step enable.
- Qi, Qc, Qw, Ql, out, 1 each, one-hot state flags: idle, playing, won, lost.
- Food, out, 8, food cell index (row*16+col).
- Length, out, 4, current segment count.
- Locations_Flat, out, 128, segment i at bits [127-8i -: 8]; segment 0 (head) in [127:120].

## Operation
- Grid 16x16; cell index = row*16+col.
- States: INIT, PLACE, PLAY, WIN, LOSE. Qi=INIT, Qc=PLAY, Qw=WIN, Ql=LOSE. During PLACE all four flags are 0.
- INIT: Length=0, locations=0. On Start, load seg i = START_POS-i for i<START_LEN (others 0), Length=START_LEN, dir=RIGHT, then go to PLACE.
- PLACE: candidate = current LFSR value. Accept when the candidate matches no segment i<Length. On acceptance, Food<=candidate and go to PLAY; otherwise stay. Cell 0 is never chosen (LFSR is non-zero).
- LFSR: 8-bit Fibonacci shift-left, feedback = l[7]^l[5]^l[4]^l[3]. Free-runs every cycle in every state.
- Direction latch: a pending direction takes the pulsed button, priority U>D>L>R. A press opposite to the current applied direction is discarded. The pending direction becomes the applied direction on each Tick in PLAY.
- PLAY on Tick, using the applied direction d:
  - Wall check: U at row 0, D at row 15, L at col 0, R at col 15 -> LOSE; body unchanged.
  - nh = head-16 (U), +16 (D), -1 (L) or +1 (R).
  - Eat (nh==Food): shift body down one slot, seg0<=nh, Length+1. If the new Length==WIN_LEN -> WIN, else -> PLACE.
  - Otherwise, self-check: nh equals any seg i<Length-1 -> LOSE, body unchanged (the tail slot is vacating, so it is excluded). Else shift in nh, drop the tail, Length unchanged.
  - Segment slots ≥Length hold don't-care but are driven to 0 on every INIT entry.
- WIN/LOSE: outputs frozen. Start -> INIT.
- Tick outside PLAY is ignored, including Tick during PLACE (that step is lost). Start outside INIT/WIN/LOSE is ignored. Button pulses are latched in any state but reset to RIGHT on the INIT->PLACE load.
- Simultaneous Tick and button in the same cycle: the move uses the previously pending direction; the new press becomes pending for the next Tick.

## Timing
- All outputs are registered.
- A Tick sampled on edge N produces updated Locations_Flat, Length and flags after edge N.
- PLACE takes ≥1 cycle, and one cycle per rejected candidate.
- Reset (async, at any time, including mid-PLACE or mid-move): state=INIT, Qi=1, Qc=Qw=Ql=0, Food=0, Length=0, Locations_Flat=0, dir=pending=RIGHT, LFSR=LFSR_SEED.

## Test plan
- Reset then Start -> Qi=0. Length=3, Locations_Flat[127:104]=88_87_86. Qc=1 within ≤256 cycles, with Food not in {88,87,86} and Food≠0.
- Three Ticks, no buttons, food placed off row 8 -> head=8B, segs 8B,8A,89, Length=3. Then BtnL followed by a Tick -> head=8C (reversal discarded).
- BtnU then 9 Ticks from head 88 -> 8th Tick head=08, 9th Tick -> Ql=1, locations unchanged. Then Start -> Qi=1, Length=0.
- Force Food=89 (pre-seed) with head 88 moving R, then Tick -> head=89, Length=4, tail 86 retained, state PLACE (all flags 0), then Qc=1 with new Food.
- Self-collision: grow to Length 5 and issue U, L, D -> Ql=1 on the Tick where nh hits a body segment. Same geometry at Length 4, where nh hits the tail -> no loss.
- WIN_LEN=5, START_LEN=3, eat twice -> Qw=1 after the second eat Tick. Further Ticks and buttons leave outputs unchanged. Assert Reset mid-PLACE -> all outputs equal their reset values immediately.
